// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-port load/store controller with valid/ready request and response handshakes.
// Optional memory-mapped output register at MMIO_ADDR, enabled by defining LSU_MMIO_EN.
`default_nettype none

module lsu_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out
);

`ifdef LSU_MMIO_EN
  localparam logic c_MMIO_EN = 1'b1;
`else
  localparam logic c_MMIO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RDATA = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_out;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_mem_we;

  logic                w_req_mmio;
  logic                w_cur_mmio;

  // The RAM strobe is registered at acceptance, so the MMIO decode must look at the incoming address.
  assign w_req_mmio = c_MMIO_EN && (req_addr == MMIO_ADDR);
  assign w_cur_mmio = c_MMIO_EN && (r_addr == MMIO_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_out        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (req_we) begin
              r_state  <= WRITE;
              r_mem_we <= !w_req_mmio;
            end else begin
              r_state  <= READ;
            end
          end
        end
        WRITE: begin
          r_mem_we     <= 1'b0;
          if (w_cur_mmio) begin
            r_out <= r_wdata;
          end
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
        end
        READ: begin
          r_state <= RDATA;
        end
        RDATA: begin
          r_rdata      <= w_cur_mmio ? r_out : mem_rdata;
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_mem_we     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_mem_we;
  assign out        = r_out;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a transaction-level memory model.
`default_nettype none

module tb_lsu_ctrl;

`ifdef LSU_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [15:0] out;

  lsu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .out        (out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM seen by the controller: read data one cycle after the address.
  logic [15:0] env_ram [256];
  int          n_writes = 0;
  always @(posedge clk) begin
    mem_rdata <= env_ram[mem_addr];
    if (mem_we === 1'b1) begin
      env_ram[mem_addr] = mem_wdata;
      n_writes++;
    end
  end

  // Reference model: what memory, the output register and the last load result should hold.
  logic [15:0] ref_mem [256];
  logic [15:0] ref_out;
  logic [15:0] ref_last;
  int          exp_writes;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_junk(input bit junk);
    if (junk) begin
      req_valid = 1'b1;
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 16'($urandom);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // One complete access from the IDLE cycle through the return to IDLE.
  task automatic access(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        input int stall, input bit junk);
    bit hit;
    int n_resp;
    hit    = MMIO_ON && (addr == 8'hFF);
    n_resp = (stall == 0) ? 1 : stall;
    chk("req_ready_idle", req_ready, 1);
    chk("resp_valid_idle", resp_valid, 0);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (stall == 0);
    @(negedge clk);
    drive_junk(junk);
    chk("req_ready_busy", req_ready, 0);
    chk("resp_valid_busy", resp_valid, 0);
    chk("mem_addr", mem_addr, addr);
    if (we) begin
      chk("mem_we_write", mem_we, !hit);
      chk("mem_wdata", mem_wdata, wdata);
      if (hit) ref_out = wdata;
      else begin
        ref_mem[addr] = wdata;
        exp_writes++;
      end
    end else begin
      chk("mem_we_read", mem_we, 0);
      @(negedge clk);
      drive_junk(junk);
      chk("resp_valid_rdata", resp_valid, 0);
      chk("mem_we_rdata", mem_we, 0);
      ref_last = hit ? ref_out : ref_mem[addr];
    end
    @(negedge clk);
    for (int i = 0; i < n_resp; i++) begin
      chk("resp_valid_resp", resp_valid, 1);
      chk("req_ready_resp", req_ready, 0);
      chk("mem_we_resp", mem_we, 0);
      chk("resp_rdata", resp_rdata, ref_last);
      chk("out_resp", out, ref_out);
      drive_junk(junk);
      resp_ready = (i == n_resp - 1);
      @(negedge clk);
    end
    chk("req_ready_after", req_ready, 1);
    chk("resp_valid_after", resp_valid, 0);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  a;
    n_checks   = 0;
    n_fail     = 0;
    exp_writes = 0;
    ref_out    = '0;
    ref_last   = '0;
    for (int i = 0; i < 256; i++) begin
      env_ram[i] = 16'($urandom);
      ref_mem[i] = env_ram[i];
    end
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_out", out, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    @(negedge clk);

    // Store then load at 0x10, back-to-back at minimum spacing.
    access(1'b1, 8'h10, 16'h0002, 0, 1'b0);
    access(1'b0, 8'h10, 16'h0000, 0, 1'b0);
    chk("load_0x10", resp_rdata, 16'h0002);

    // Output register address: RAM in the default build, output register with MMIO.
    access(1'b1, 8'hFF, 16'h0004, 0, 1'b0);
    chk("out_after_ff_store", out, MMIO_ON ? 16'h0004 : 16'h0000);
    access(1'b0, 8'hFF, 16'h0000, 0, 1'b0);
    chk("load_0xff", resp_rdata, 16'h0004);

    // Held response with a competing request that must be ignored.
    access(1'b0, 8'h10, 16'h0000, 5, 1'b1);

    // Reset during the WRITE cycle of a store to 0x20.
    d = 16'hA55A;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = d;
    @(negedge clk);
    chk("rstw_mem_we", mem_we, 1);
    req_valid = 1'b0;
    rst = 1'b1;
    ref_mem[8'h20] = d;   // the RAM samples the strobe on the reset edge itself
    exp_writes++;
    @(negedge clk);
    rst = 1'b0;
    ref_out  = '0;
    ref_last = '0;
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_out", out, 0);
    chk("rstw_resp_rdata", resp_rdata, 0);
    repeat (4) begin
      @(negedge clk);
      chk("rstw_no_resp", resp_valid, 0);
      chk("rstw_no_we", mem_we, 0);
    end
    access(1'b0, 8'h20, 16'h0000, 0, 1'b0);

    // Randomized traffic with stalls and ignored requests while busy.
    for (int t = 0; t < 60; t++) begin
      case ($urandom % 3)
        0:       a = 8'hFF;
        1:       a = 8'($urandom % 8);
        default: a = 8'($urandom);
      endcase
      d = 16'($urandom);
      access(1'($urandom), a, d, (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0,
             1'($urandom));
      chk("out_idle", out, ref_out);
    end

    chk("write_count", n_writes, exp_writes);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
